// File: rtl/sprite_coin_lane_if.sv
// rtl/sprite_coin_lane_if.sv - pixel/frame bus between video timing (master) and one coin lane (slave)
interface sprite_coin_lane_if;
  logic        i_v_sync;
  logic [15:0] i_x;
  logic [15:0] i_y;
  logic [15:0] i_penguin_x;
  logic        i_is_finished;
  logic        i_is_dead;
  logic [7:0]  o_red;
  logic [7:0]  o_green;
  logic [7:0]  o_blue;
  logic        o_sprite_hit;
  logic        o_scored;
  logic        o_missed;
  logic [7:0]  o_coin_cnt;

  modport master (
    output i_v_sync, i_x, i_y, i_penguin_x, i_is_finished, i_is_dead,
    input  o_red, o_green, o_blue, o_sprite_hit, o_scored, o_missed, o_coin_cnt
  );

  modport slave (
    input  i_v_sync, i_x, i_y, i_penguin_x, i_is_finished, i_is_dead,
    output o_red, o_green, o_blue, o_sprite_hit, o_scored, o_missed, o_coin_cnt
  );
endinterface

// File: rtl/sprite_coin_lane.sv
// rtl/sprite_coin_lane.sv - falling coin sprite in one lane: spawn/fall/collect FSM and pixel renderer
// Optional collected-coin counter enabled by COIN_SCORE_CNT_EN.
module sprite_coin_lane #(
  parameter int LANE_X_CENTER = 640,
  parameter int LANE_OFFSET   = 0,
  parameter int PENGUIN_X     = 576,
  parameter int SPEED         = 1,
  parameter int Y_END         = 592,
  parameter int SCALE1_Y      = 300,
  parameter int SCALE2_Y      = 450,
  parameter int HIT_Y_MIN     = 540,
  parameter int HIT_Y_MAX     = 550,
  parameter int VIS_Y_MIN     = 144,
  parameter int SPAWN_DELAY   = 1000
) (
  input logic              i_clk,
  input logic              i_rst,
  sprite_coin_lane_if.slave bus
);

  localparam logic [15:0] LANE_C   = 16'(LANE_X_CENTER);
  localparam logic [15:0] OFFS_W   = 16'(LANE_OFFSET);
  localparam logic [15:0] PENG_W   = 16'(PENGUIN_X);
  localparam logic [15:0] SPEED_W  = 16'(SPEED);
  localparam logic [16:0] SPEED17  = 17'(SPEED);
  localparam logic [15:0] Y_END_W  = 16'(Y_END);
  localparam logic [16:0] Y_END17  = 17'(Y_END);
  localparam logic [15:0] SCALE1_W = 16'(SCALE1_Y);
  localparam logic [15:0] SCALE2_W = 16'(SCALE2_Y);
  localparam logic [15:0] HIT_MIN  = 16'(HIT_Y_MIN);
  localparam logic [15:0] HIT_MAX  = 16'(HIT_Y_MAX);
  localparam logic [15:0] VIS_MIN  = 16'(VIS_Y_MIN);
  localparam logic [15:0] SPAWN_W  = 16'(SPAWN_DELAY);

  // Coin artwork: yellow border ring around a pale fill disc, rows 5..26 populated.
  function automatic logic [2047:0] coin_art();
    logic [2047:0] art;
    int dr;
    int dc;
    int d2;
    art = '0;
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        dr = 2 * r - 31;
        dc = 2 * c - 31;
        d2 = dr * dr + dc * dc;
        if (d2 <= 324)      art[(r * 32 + c) * 2 +: 2] = 2'd2;
        else if (d2 <= 484) art[(r * 32 + c) * 2 +: 2] = 2'd1;
      end
    end
    return art;
  endfunction

  localparam logic [2047:0] COIN_ART = coin_art();

  typedef enum logic [1:0] {
    WAIT      = 2'd0,
    FALL      = 2'd1,
    COLLECTED = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] y, y_next;
  logic [15:0] delay, delay_next;
  logic        v_sync_q;
  logic        tick;
  logic        scored_next, missed_next;

  // The edge register keeps tracking while the game is paused so a held strobe never fires late.
  assign tick = bus.i_v_sync & ~v_sync_q & ~bus.i_is_finished & ~bus.i_is_dead;

  always_comb begin
    state_next  = state;
    y_next      = y;
    delay_next  = delay;
    scored_next = 1'b0;
    missed_next = 1'b0;
    if (tick) begin
      case (state)
        FALL: begin
          if (y > HIT_MIN && y < HIT_MAX && bus.i_penguin_x == PENG_W) begin
            state_next  = COLLECTED;
            scored_next = 1'b1;
          end else if ({1'b0, y} + SPEED17 >= Y_END17) begin
            state_next  = WAIT;
            y_next      = Y_END_W;
            missed_next = 1'b1;
          end else begin
            y_next = y + SPEED_W;
          end
        end
        WAIT, COLLECTED: begin
          if (delay + 16'd1 == SPAWN_W) begin
            state_next = FALL;
            y_next     = 16'd0;
            delay_next = 16'd0;
          end else begin
            delay_next = delay + 16'd1;
          end
        end
        default: state_next = WAIT;
      endcase
    end
  end

  logic [1:0]  sh;
  logic [15:0] sprite_x;
  logic [15:0] span;
  logic [15:0] off_x, off_y;
  logic [4:0]  col, row;
  logic [1:0]  pix;
  logic        in_box;
  logic [23:0] pal_rgb;

  always_comb begin
    if (y < SCALE1_W)      sh = 2'd0;
    else if (y < SCALE2_W) sh = 2'd1;
    else                   sh = 2'd2;
  end

  assign sprite_x = LANE_C - (16'd16 << sh) + (OFFS_W << sh);
  assign span     = 16'd32 << sh;
  assign in_box   = (bus.i_x >= sprite_x) && (bus.i_x < sprite_x + span) &&
                    (bus.i_y >= y) && (bus.i_y < y + span);
  assign off_x    = bus.i_x - sprite_x;
  assign off_y    = bus.i_y - y;
  assign col      = 5'(off_x >> sh);
  assign row      = 5'(off_y >> sh);
  assign pix      = COIN_ART[{row, col, 1'b0} +: 2];

  always_comb begin
    case (pix)
      2'd1:    pal_rgb = 24'hFFDB00;
      2'd2:    pal_rgb = 24'hFFF2A5;
      default: pal_rgb = 24'h000000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= WAIT;
      y                <= Y_END_W;
      delay            <= 16'd0;
      v_sync_q         <= 1'b0;
      bus.o_red        <= 8'd0;
      bus.o_green      <= 8'd0;
      bus.o_blue       <= 8'd0;
      bus.o_sprite_hit <= 1'b0;
      bus.o_scored     <= 1'b0;
      bus.o_missed     <= 1'b0;
    end else begin
      state        <= state_next;
      y            <= y_next;
      delay        <= delay_next;
      v_sync_q     <= bus.i_v_sync;
      bus.o_scored <= scored_next;
      bus.o_missed <= missed_next;
      if (state == FALL && in_box) begin
        bus.o_red   <= pal_rgb[23:16];
        bus.o_green <= pal_rgb[15:8];
        bus.o_blue  <= pal_rgb[7:0];
      end else begin
        bus.o_red   <= 8'd0;
        bus.o_green <= 8'd0;
        bus.o_blue  <= 8'd0;
      end
      bus.o_sprite_hit <= (state == FALL) && (y >= VIS_MIN) && (y < Y_END_W) &&
                          in_box && (pix != 2'd0);
    end
  end

`ifdef COIN_SCORE_CNT_EN
  logic [7:0] coin_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      coin_cnt <= 8'd0;
    end else if (scored_next && coin_cnt != 8'hFF) begin
      coin_cnt <= coin_cnt + 8'd1;
    end
  end

  assign bus.o_coin_cnt = coin_cnt;
`else
  assign bus.o_coin_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sprite_coin_lane.sv
// tb/tb_sprite_coin_lane.sv - scoreboard bench for sprite_coin_lane (centre lane and offset lane instances)
module tb_sprite_coin_lane;

  localparam int ST_WAIT = 0;
  localparam int ST_FALL = 1;
  localparam int ST_COLL = 2;
`ifdef COIN_SCORE_CNT_EN
  localparam int EXP_CNT = 1;
`else
  localparam int EXP_CNT = 0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  sprite_coin_lane_if bus ();
  sprite_coin_lane_if bus2 ();

  assign bus2.i_v_sync      = bus.i_v_sync;
  assign bus2.i_x           = bus.i_x;
  assign bus2.i_y           = bus.i_y;
  assign bus2.i_penguin_x   = bus.i_penguin_x;
  assign bus2.i_is_finished = bus.i_is_finished;
  assign bus2.i_is_dead     = bus.i_is_dead;

  sprite_coin_lane dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  sprite_coin_lane #(.LANE_OFFSET(100)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [23:0] rgb;
    logic        hit;
    logic [23:0] rgb2;
    logic        hit2;
  } pix_exp_t;

  pix_exp_t sb[$];
  int       n_scored;
  int       n_missed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(output logic sc, output logic ms);
    @(negedge clk);
    bus.i_v_sync = 1'b1;
    @(negedge clk);
    sc = bus.o_scored;
    ms = bus.o_missed;
    bus.i_v_sync = 1'b0;
  endtask

  task automatic tick_n(input int n);
    logic sc, ms;
    for (int i = 0; i < n; i++) begin
      tick(sc, ms);
      if (sc) n_scored++;
      if (ms) n_missed++;
    end
  endtask

  task automatic pixel(input string tag, input logic [15:0] x, input logic [15:0] yy,
                       input logic [23:0] rgb, input logic hit,
                       input logic [23:0] rgb2, input logic hit2);
    pix_exp_t e;
    @(negedge clk);
    bus.i_x = x;
    bus.i_y = yy;
    e.tag = tag; e.rgb = rgb; e.hit = hit; e.rgb2 = rgb2; e.hit2 = hit2;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, "_rgb"},  {bus.o_red, bus.o_green, bus.o_blue}, e.rgb);
    check({e.tag, "_hit"},  bus.o_sprite_hit, e.hit);
    check({e.tag, "_rgb2"}, {bus2.o_red, bus2.o_green, bus2.o_blue}, e.rgb2);
    check({e.tag, "_hit2"}, bus2.o_sprite_hit, e.hit2);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sc, ms;
    n_checks = 0; n_errors = 0; n_scored = 0; n_missed = 0;
    rst = 1'b1;
    bus.i_v_sync = 1'b0; bus.i_x = 16'd0; bus.i_y = 16'd0;
    bus.i_penguin_x = 16'd0; bus.i_is_finished = 1'b0; bus.i_is_dead = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(dut.state), ST_WAIT);
    check("rst_y", dut.y, 592);
    check("rst_delay", dut.delay, 0);
    check("rst_out", {bus.o_red, bus.o_green, bus.o_blue, bus.o_sprite_hit,
                      bus.o_scored, bus.o_missed}, 0);
    check("rst_cnt", bus.o_coin_cnt, 0);
    rst = 1'b0;

    tick_n(999);
    check("spawn_999_state", 32'(dut.state), ST_WAIT);
    tick_n(1);
    check("spawn_1000_state", 32'(dut.state), ST_FALL);
    check("spawn_1000_y", dut.y, 0);
    check("spawn_delay_clr", dut.delay, 0);

    bus.i_is_dead = 1'b1;
    tick(sc, ms);
    check("dead_tick_y", dut.y, 0);
    bus.i_is_dead = 1'b0;
    bus.i_is_finished = 1'b1;
    tick(sc, ms);
    check("fin_tick_y", dut.y, 0);
    bus.i_is_finished = 1'b0;
    tick(sc, ms);
    check("resume_tick_y", dut.y, 1);

    tick_n(99);
    check("y100", dut.y, 100);
    pixel("px_y100", 16'd640, 16'd116, 24'hFFF2A5, 1'b0, 24'h000000, 1'b0);

    tick_n(360);
    check("off_sprite_x", dut2.sprite_x, 976);
    pixel("px_off_lane", 16'd1040, 16'd524, 24'h000000, 1'b0, 24'hFFF2A5, 1'b1);

    tick_n(40);
    check("y500", dut.y, 500);
    pixel("px_y500_fill", 16'd640, 16'd564, 24'hFFF2A5, 1'b1, 24'h000000, 1'b0);
    pixel("px_y500_corner", 16'd576, 16'd500, 24'h000000, 1'b0, 24'h000000, 1'b0);
    pixel("px_left_edge", 16'd575, 16'd564, 24'h000000, 1'b0, 24'h000000, 1'b0);

    tick_n(45);
    check("y545", dut.y, 545);
    check("no_pulse_fall", n_scored + n_missed, 0);
    bus.i_penguin_x = 16'd576;
    tick(sc, ms);
    check("collect_scored", sc, 1);
    check("collect_missed", ms, 0);
    check("collect_state", 32'(dut.state), ST_COLL);
    check("collect_cnt", bus.o_coin_cnt, EXP_CNT);
    bus.i_penguin_x = 16'd0;
    @(negedge clk);
    check("scored_one_clk", bus.o_scored, 0);

    tick_n(1000);
    check("respawn_state", 32'(dut.state), ST_FALL);
    check("respawn_y", dut.y, 0);

    tick_n(591);
    check("y591", dut.y, 591);
    tick(sc, ms);
    check("miss_pulse", ms, 1);
    check("miss_scored", sc, 0);
    check("miss_y", dut.y, 592);
    check("miss_state", 32'(dut.state), ST_WAIT);
    @(negedge clk);
    check("missed_one_clk", bus.o_missed, 0);
    n_scored = 0; n_missed = 0;
    tick_n(999);
    check("wait_999_state", 32'(dut.state), ST_WAIT);
    tick_n(1);
    check("rearm_state", 32'(dut.state), ST_FALL);
    check("rearm_y", dut.y, 0);
    check("rearm_pulses", n_scored + n_missed, 0);

    tick_n(50);
    @(negedge clk);
    bus.i_x = 16'd640;
    bus.i_y = 16'd66;
    rst = 1'b1;
    bus.i_v_sync = 1'b1;
    @(negedge clk);
    check("rst_tick_y", dut.y, 592);
    check("rst_tick_state", 32'(dut.state), ST_WAIT);
    check("rst_tick_out", {bus.o_red, bus.o_green, bus.o_blue, bus.o_sprite_hit,
                           bus.o_scored, bus.o_missed}, 0);
    check("rst_tick_cnt", bus.o_coin_cnt, 0);
    check("rst_tick_delay", dut.delay, 0);
    rst = 1'b0;
    bus.i_v_sync = 1'b0;
    @(negedge clk);
    check("rst_no_miss", bus.o_missed, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_coin_lane.md
SPRITE_COIN_LANE -- requirements
Module: sprite_coin_lane

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- LANE_X_CENTER, 640, lane centre x at scale 1.
- LANE_OFFSET, 0, signed x drift per scale unit (0 = centre lane).
- PENGUIN_X, 576, penguin x that collects the coin.
- SPEED, 1, y pixels advanced per frame.
- Y_END, 592, last y before the coin leaves the track.
- SCALE1_Y, 300, y below which the scale is 1.
- SCALE2_Y, 450, y below which the scale is 2; 4 otherwise.
- HIT_Y_MIN, 540 and HIT_Y_MAX, 550, exclusive collect window.
- VIS_Y_MIN, 144, minimum y for o_sprite_hit.
- SPAWN_DELAY, 1000, frames hidden before respawn (1..65535).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- i_clk, in, 1, single clock.
- i_rst, in, 1, synchronous active-high reset.
- i_v_sync, in, 1, frame strobe, synchronous to i_clk.
- i_x, in, 16, current pixel x.
- i_y, in, 16, current pixel y.
- i_penguin_x, in, 16, player x.
- i_is_finished, in, 1, game finished.
- i_is_dead, in, 1, player dead.
- o_red, out, 8, pixel red.
- o_green, out, 8, pixel green.
- o_blue, out, 8, pixel blue.
- o_sprite_hit, out, 1, opaque coin pixel.
- o_scored, out, 1, one-clock collect pulse.
- o_missed, out, 1, one-clock miss pulse.
- o_coin_cnt, out, 8, collected-coin count.

Function
REQ-003 A frame tick SHALL be the rising edge of i_v_sync, detected with one register (i_v_sync high while the registered copy is low); exactly one tick per edge.
REQ-004 A tick SHALL be ignored, with all state held, while i_is_finished or i_is_dead is high.
REQ-005 The FSM SHALL have three states: WAIT (hidden, counting), FALL (moving) and COLLECTED (hidden, counting).
REQ-006 On a FALL tick, collect is checked first. If HIT_Y_MIN < y < HIT_Y_MAX on the pre-tick y and i_penguin_x == PENGUIN_X, the FSM SHALL go to COLLECTED and assert o_scored for that one clock.
REQ-007 Otherwise, on a FALL tick with y+SPEED >= Y_END, the FSM SHALL clamp y to Y_END, go to WAIT and assert o_missed for one clock. With no collect and no end, y SHALL advance by SPEED.
REQ-008 In WAIT and COLLECTED, each tick SHALL increment a 16-bit delay counter. On the tick where the counter reaches SPAWN_DELAY, the FSM SHALL go to FALL with y=0 and the counter cleared.
REQ-009 Scale s SHALL be 1 if y<SCALE1_Y, 2 if y<SCALE2_Y, else 4. Sprite x SHALL be LANE_X_CENTER - 16*s + LANE_OFFSET*s, in 16-bit wrap arithmetic.
REQ-010 The coin SHALL be in box when sprite_x <= i_x < sprite_x+32*s and y <= i_y < y+32*s. The bitmap index SHALL be (offset >> log2 s), truncated to 5 bits.
REQ-011 The bitmap SHALL be the team's 32x32 2-bit coin artwork, with rows 5..26 non-zero. Palette: 0 = 000000, 1 = FFDB00 (border), 2 = FFF2A5 (fill).
REQ-012 RGB outputs SHALL be registered with 1-clock latency from i_x/i_y. Output the palette colour when in FALL and in box, else 000000.
REQ-013 o_sprite_hit SHALL be registered with the same latency. Assert it only when in FALL, VIS_Y_MIN <= y < Y_END, in box and palette index != 0.
REQ-014 o_scored and o_missed SHALL never assert in the same clock.

Reset
REQ-015 i_rst SHALL set the state to WAIT, y=Y_END, delay=0, edge register=0, all outputs 0 and o_coin_cnt=0. Reset SHALL take priority over a simultaneous tick.
REQ-016 Reset mid-FALL SHALL abort the coin without an o_missed pulse.

Configuration
REQ-017 With COIN_SCORE_CNT_EN defined, o_coin_cnt SHALL increment on each o_scored and saturate at 255.
REQ-018 Without COIN_SCORE_CNT_EN, o_coin_cnt SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-019 Reset, then 1000 ticks -> state FALL, y=0. A tick while i_is_dead=1 -> y unchanged.
REQ-020 In FALL with y=100, pixel (i_x=624+16, i_y=116) -> next clock RGB=FFF2A5, o_sprite_hit=0 (y<VIS_Y_MIN).
REQ-021 y=500 (s=4, sprite_x=576), pixel (640,564) -> RGB=FFF2A5, o_sprite_hit=1. Pixel (576,500) -> RGB=000000, o_sprite_hit=0.
REQ-022 y=545, i_penguin_x=576, tick -> o_scored one clock, state COLLECTED, o_coin_cnt 0->1 (macro on) or stays 0 (macro off).
REQ-023 y=591, i_penguin_x=0, tick -> y=592, o_missed one clock, WAIT. After 1000 further ticks -> FALL, y=0.
REQ-024 LANE_OFFSET=100, y=460 -> sprite_x=976. Assert i_rst coincident with a tick -> y=592, all outputs 0.
